// File: rtl/isolde_xif_issue_seq.sv
// CV-X-IF issue/commit sequencer with result scoreboard and writeback.
// Optional: ISOLDE_XIF_SEQ_TIMEOUT_EN retires stale entries after TimeoutCycles.
module isolde_xif_issue_seq #(
  parameter int XLEN           = 32,
  parameter int NumRs          = 3,
  parameter int IdWidth        = 4,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                              clk,
  input  logic                              g_rst_n,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [31:0]                       req_instr_i,
  input  logic [NumRs*XLEN-1:0]             req_rs_i,
  input  logic [NumRs-1:0]                  req_rs_valid_i,
  output logic                              issue_valid_o,
  input  logic                              issue_ready_i,
  output logic [31:0]                       issue_instr_o,
  output logic [NumRs*XLEN-1:0]             issue_rs_o,
  output logic [NumRs-1:0]                  issue_rs_valid_o,
  output logic [IdWidth-1:0]                issue_id_o,
  input  logic                              issue_accept_i,
  input  logic                              issue_writeback_i,
  output logic                              commit_valid_o,
  output logic [IdWidth-1:0]                commit_id_o,
  output logic                              commit_kill_o,
  input  logic                              result_valid_i,
  output logic                              result_ready_o,
  input  logic [IdWidth-1:0]                result_id_i,
  input  logic [4:0]                        result_rd_i,
  input  logic [XLEN-1:0]                   result_data_i,
  input  logic                              result_we_i,
  output logic                              wb_we_o,
  output logic [4:0]                        wb_addr_o,
  output logic [XLEN-1:0]                   wb_data_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                              busy_o,
  output logic                              reject_o,
  output logic                              err_id_o
);

  localparam int NumIds = 1 << IdWidth;
  localparam int OutW   = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             instr_q, instr_d;
  logic [NumRs*XLEN-1:0]   rs_q, rs_d;
  logic [NumRs-1:0]        rsv_q, rsv_d;
  logic [IdWidth-1:0]      id_q, id_d;
  logic [IdWidth-1:0]      nid_q, nid_d;
  logic                    kill_q, kill_d;
  logic                    run_q;
  logic [NumIds-1:0]       sb_q, sb_d;
  logic [NumIds-1:0]       expire;
  logic                    alloc, hit, miss, to_err;
  logic [IdWidth:0]        cnt;
  logic                    slot_free;
  logic                    wb_we_q;
  logic [4:0]              wb_addr_q;
  logic [XLEN-1:0]         wb_data_q;
  logic                    err_q;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NumIds; i++) begin
      cnt = cnt + (IdWidth+1)'(sb_q[i]);
    end
  end

  // A free slot also needs the next ID to be retired already.
  assign slot_free = (cnt < (IdWidth+1)'(MaxOutstanding)) && !sb_q[nid_q];

  assign req_ready_o   = run_q && (state_q == IDLE) && slot_free;
  assign busy_o        = (state_q != IDLE) ||
                         (cnt == (IdWidth+1)'(MaxOutstanding));
  assign outstanding_o = cnt[OutW-1:0];
  assign result_ready_o = run_q;

  assign issue_valid_o    = (state_q == ISSUE);
  assign issue_instr_o    = instr_q;
  assign issue_rs_o       = rs_q;
  assign issue_rs_valid_o = rsv_q;
  assign issue_id_o       = id_q;

  assign commit_valid_o = (state_q == COMMIT);
  assign commit_id_o    = commit_valid_o ? id_q : '0;
  assign commit_kill_o  = commit_valid_o && kill_q;
  assign reject_o       = commit_valid_o && kill_q;

  assign wb_we_o   = wb_we_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign err_id_o  = err_q;

  assign hit  = run_q && result_valid_i && sb_q[result_id_i];
  assign miss = run_q && result_valid_i && !sb_q[result_id_i];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rs_d    = rs_q;
    rsv_d   = rsv_q;
    id_d    = id_q;
    nid_d   = nid_q;
    kill_d  = kill_q;
    alloc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          instr_d = req_instr_i;
          rs_d    = req_rs_i;
          rsv_d   = req_rs_valid_i;
          id_d    = nid_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_ready_i) begin
          nid_d   = nid_q + 1'b1;
          kill_d  = !issue_accept_i;
          alloc   = issue_accept_i && issue_writeback_i;
          state_d = COMMIT;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sb_d = sb_q & ~expire;
    if (alloc) sb_d[id_q] = 1'b1;
    if (hit)   sb_d[result_id_i] = 1'b0;
  end

`ifdef ISOLDE_XIF_SEQ_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] tcnt_q [NumIds];

  // A result arriving on the expiry cycle wins over the timeout.
  always_comb begin
    expire = '0;
    for (int i = 0; i < NumIds; i++) begin
      expire[i] = sb_q[i] &&
                  (tcnt_q[i] == CntW'(TimeoutCycles - 1)) &&
                  !(hit && (result_id_i == IdWidth'(i)));
    end
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      for (int i = 0; i < NumIds; i++) tcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        tcnt_q[i] <= (sb_q[i] && sb_d[i]) ? tcnt_q[i] + 1'b1 : '0;
      end
    end
  end
`else
  assign expire = '0;
`endif

  assign to_err = |expire;

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rs_q      <= '0;
      rsv_q     <= '0;
      id_q      <= '0;
      nid_q     <= '0;
      kill_q    <= 1'b0;
      run_q     <= 1'b0;
      sb_q      <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rs_q    <= rs_d;
      rsv_q   <= rsv_d;
      id_q    <= id_d;
      nid_q   <= nid_d;
      kill_q  <= kill_d;
      run_q   <= 1'b1;
      sb_q    <= sb_d;
      wb_we_q <= hit && result_we_i && (result_rd_i != 5'd0);
      if (hit) begin
        wb_addr_q <= result_rd_i;
        wb_data_q <= result_data_i;
      end
      err_q <= miss || to_err;
    end
  end

endmodule

// File: tb/tb_isolde_xif_issue_seq.sv
// Directed bench for isolde_xif_issue_seq.
// Checks issue/commit, scoreboard, writeback and reset behaviour.
module tb_isolde_xif_issue_seq;

  localparam int XLEN    = 32;
  localparam int NumRs   = 3;
  localparam int IdWidth = 4;
  localparam int MaxOut  = 4;
  localparam int OutW    = $clog2(MaxOut + 1);

  logic                    clk;
  logic                    g_rst_n;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [31:0]             req_instr_i;
  logic [NumRs*XLEN-1:0]   req_rs_i;
  logic [NumRs-1:0]        req_rs_valid_i;
  logic                    issue_valid_o;
  logic                    issue_ready_i;
  logic [31:0]             issue_instr_o;
  logic [NumRs*XLEN-1:0]   issue_rs_o;
  logic [NumRs-1:0]        issue_rs_valid_o;
  logic [IdWidth-1:0]      issue_id_o;
  logic                    issue_accept_i;
  logic                    issue_writeback_i;
  logic                    commit_valid_o;
  logic [IdWidth-1:0]      commit_id_o;
  logic                    commit_kill_o;
  logic                    result_valid_i;
  logic                    result_ready_o;
  logic [IdWidth-1:0]      result_id_i;
  logic [4:0]              result_rd_i;
  logic [XLEN-1:0]         result_data_i;
  logic                    result_we_i;
  logic                    wb_we_o;
  logic [4:0]              wb_addr_o;
  logic [XLEN-1:0]         wb_data_o;
  logic [OutW-1:0]         outstanding_o;
  logic                    busy_o;
  logic                    reject_o;
  logic                    err_id_o;

  int n_run;
  int n_fail;

  isolde_xif_issue_seq #(
    .XLEN(XLEN), .NumRs(NumRs), .IdWidth(IdWidth),
    .MaxOutstanding(MaxOut), .TimeoutCycles(1024)
  ) dut (
    .clk(clk), .g_rst_n(g_rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_instr_i(req_instr_i), .req_rs_i(req_rs_i),
    .req_rs_valid_i(req_rs_valid_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_rs_o(issue_rs_o),
    .issue_rs_valid_o(issue_rs_valid_o), .issue_id_o(issue_id_o),
    .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
    .commit_kill_o(commit_kill_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_rd_i(result_rd_i),
    .result_data_i(result_data_i), .result_we_i(result_we_i),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o),
    .reject_o(reject_o), .err_id_o(err_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request/issue/commit sequence, entered and left in IDLE.
  task automatic run_op(input logic [31:0] instr, input logic acc,
                        input logic wbk, input logic [IdWidth-1:0] eid);
    chk("op_req_ready", req_ready_o, 1'b1);
    req_valid_i       = 1'b1;
    req_instr_i       = instr;
    issue_ready_i     = 1'b1;
    issue_accept_i    = acc;
    issue_writeback_i = wbk;
    tick();
    req_valid_i = 1'b0;
    chk("op_issue_valid", issue_valid_o, 1'b1);
    chk("op_issue_id", issue_id_o, eid);
    tick();
    chk("op_commit_valid", commit_valid_o, 1'b1);
    chk("op_commit_id", commit_id_o, eid);
    chk("op_commit_kill", commit_kill_o, !acc);
    chk("op_reject", reject_o, !acc);
    tick();
    chk("op_commit_end", commit_valid_o, 1'b0);
    chk("op_reject_end", reject_o, 1'b0);
  endtask

  task automatic send_result(input logic [IdWidth-1:0] id,
                             input logic [4:0] rd,
                             input logic [31:0] data, input logic we);
    result_valid_i = 1'b1;
    result_id_i    = id;
    result_rd_i    = rd;
    result_data_i  = data;
    result_we_i    = we;
    tick();
    result_valid_i = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    g_rst_n           = 1'b0;
    req_valid_i       = 1'b0;
    req_instr_i       = '0;
    req_rs_i          = '0;
    req_rs_valid_i    = '0;
    issue_ready_i     = 1'b0;
    issue_accept_i    = 1'b0;
    issue_writeback_i = 1'b0;
    result_valid_i    = 1'b0;
    result_id_i       = '0;
    result_rd_i       = '0;
    result_data_i     = '0;
    result_we_i       = 1'b0;

    #2;
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_issue_valid", issue_valid_o, 1'b0);
    chk("rst_commit_valid", commit_valid_o, 1'b0);
    chk("rst_result_ready", result_ready_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wb_we", wb_we_o, 1'b0);
    chk("rst_err", err_id_o, 1'b0);
    #10 g_rst_n = 1'b1;
    tick();
    chk("post_rst_result_ready", result_ready_o, 1'b1);

    // Single op with writeback
    req_rs_i       = {32'd3, 32'd2, 32'd1};
    req_rs_valid_i = 3'b111;
    chk("single_busy_idle", busy_o, 1'b0);
    req_valid_i       = 1'b1;
    req_instr_i       = 32'h0000_702B;
    issue_ready_i     = 1'b1;
    issue_accept_i    = 1'b1;
    issue_writeback_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    req_rs_i    = '0;
    chk("single_issue_valid", issue_valid_o, 1'b1);
    chk("single_issue_id", issue_id_o, 0);
    chk("single_instr", issue_instr_o, 32'h0000_702B);
    chk("single_rs_lo", issue_rs_o[63:0], 64'h0000_0002_0000_0001);
    chk("single_rs_hi", issue_rs_o[95:64], 32'd3);
    chk("single_rs_valid", issue_rs_valid_o, 3'b111);
    chk("single_busy", busy_o, 1'b1);
    tick();
    chk("single_commit", commit_valid_o, 1'b1);
    chk("single_kill", commit_kill_o, 1'b0);
    chk("single_issue_drop", issue_valid_o, 1'b0);
    chk("single_outstanding", outstanding_o, 1);
    tick();
    chk("single_commit_pulse", commit_valid_o, 1'b0);
    send_result(4'd0, 5'd5, 32'hDEAD_BEEF, 1'b1);
    chk("single_wb_we", wb_we_o, 1'b1);
    chk("single_wb_addr", wb_addr_o, 5'd5);
    chk("single_wb_data", wb_data_o, 32'hDEAD_BEEF);
    chk("single_out_zero", outstanding_o, 0);
    tick();
    chk("single_wb_pulse", wb_we_o, 1'b0);

    // Issue back-pressure: ready low for 5 cycles, accepted w/o writeback
    req_valid_i       = 1'b1;
    req_instr_i       = 32'h1234_567B;
    issue_ready_i     = 1'b0;
    issue_accept_i    = 1'b1;
    issue_writeback_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    req_instr_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 6; k++) begin
      chk("bp_issue_valid", issue_valid_o, 1'b1);
      chk("bp_instr", issue_instr_o, 32'h1234_567B);
      chk("bp_id", issue_id_o, 1);
      chk("bp_req_ready", req_ready_o, 1'b0);
      chk("bp_busy", busy_o, 1'b1);
      if (k == 5) issue_ready_i = 1'b1;
      tick();
    end
    chk("bp_commit", commit_valid_o, 1'b1);
    chk("bp_commit_id", commit_id_o, 1);
    tick();
    chk("bp_no_count", outstanding_o, 0);

    // Reject
    run_op(32'h0000_002B, 1'b0, 1'b1, 4'd2);
    chk("rej_outstanding", outstanding_o, 0);
    chk("rej_no_wb", wb_we_o, 1'b0);

    // Result to rd=0 suppresses writeback
    run_op(32'h0000_102B, 1'b1, 1'b1, 4'd3);
    chk("rd0_outstanding", outstanding_o, 1);
    send_result(4'd3, 5'd0, 32'h5555_AAAA, 1'b1);
    chk("rd0_wb_we", wb_we_o, 1'b0);
    chk("rd0_err", err_id_o, 1'b0);
    chk("rd0_retired", outstanding_o, 0);

    // Unknown ID
    send_result(4'd9, 5'd4, 32'h1111_2222, 1'b1);
    chk("unk_err", err_id_o, 1'b1);
    chk("unk_wb_we", wb_we_o, 1'b0);
    chk("unk_outstanding", outstanding_o, 0);
    tick();
    chk("unk_err_pulse", err_id_o, 1'b0);

    // Reset mid-ISSUE with one entry outstanding
    run_op(32'h0000_202B, 1'b1, 1'b1, 4'd4);
    chk("rst_pre_out", outstanding_o, 1);
    req_valid_i   = 1'b1;
    req_instr_i   = 32'h0000_302B;
    issue_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    chk("rst_in_issue", issue_valid_o, 1'b1);
    g_rst_n = 1'b0;
    #1;
    chk("mid_rst_issue_valid", issue_valid_o, 1'b0);
    chk("mid_rst_instr", issue_instr_o, 0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_out", outstanding_o, 0);
    chk("mid_rst_result_ready", result_ready_o, 1'b0);
    #3 g_rst_n = 1'b1;
    tick();

    // Saturation: IDs restart at 0
    run_op(32'h0000_402B, 1'b1, 1'b1, 4'd0);
    run_op(32'h0000_412B, 1'b1, 1'b1, 4'd1);
    run_op(32'h0000_422B, 1'b1, 1'b1, 4'd2);
    run_op(32'h0000_432B, 1'b1, 1'b1, 4'd3);
    chk("sat_outstanding", outstanding_o, 4);
    chk("sat_busy", busy_o, 1'b1);
    chk("sat_req_ready", req_ready_o, 1'b0);
    send_result(4'd2, 5'd7, 32'h0000_1234, 1'b1);
    chk("sat_wb_we", wb_we_o, 1'b1);
    chk("sat_wb_addr", wb_addr_o, 5'd7);
    chk("sat_wb_data", wb_data_o, 32'h0000_1234);
    chk("sat_out_3", outstanding_o, 3);
    chk("sat_req_ready_free", req_ready_o, 1'b1);

    // Next op takes ID 4; a result for ID 0 lands on the allocation cycle
    req_valid_i = 1'b1;
    req_instr_i = 32'h0000_502B;
    tick();
    req_valid_i = 1'b0;
    chk("same_issue_id", issue_id_o, 4);
    result_valid_i = 1'b1;
    result_id_i    = 4'd0;
    result_rd_i    = 5'd3;
    result_data_i  = 32'hCAFE_F00D;
    result_we_i    = 1'b1;
    tick();
    result_valid_i = 1'b0;
    chk("same_outstanding", outstanding_o, 3);
    chk("same_wb_we", wb_we_o, 1'b1);
    chk("same_wb_data", wb_data_o, 32'hCAFE_F00D);
    chk("same_commit_id", commit_id_o, 4);
    tick();
    chk("same_idle_out", outstanding_o, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/isolde_xif_issue_seq.md
Name: isolde_xif_issue_seq

Overview:
Downstream stage of the ISOLDE execute block. Takes a single pending coprocessor request (instr + up to 3 operands) and drives the CV-X-IF issue handshake, then the commit handshake. Tracks outstanding transaction IDs in a scoreboard, collects results and writes them back to the scalar register file. Provides back-pressure (busy) upstream so the execute stage stalls while no slot is free.

Parameters:
XLEN, 32, operand/result data width
NumRs, 3, number of source operands per request
IdWidth, 4, X-IF transaction ID width
MaxOutstanding, 4, max issued-but-unretired transactions (1..2**IdWidth)
TimeoutCycles, 1024, result timeout (optional feature only)

Ports:
clk  in  1  clock
g_rst_n  in  1  reset, asynchronous, active-low
req_valid_i  in  1  upstream request valid
req_ready_o  out  1  upstream request accepted this cycle
req_instr_i  in  32  offloaded instruction word
req_rs_i  in  NumRs*XLEN  operands, rs[0] in LSBs
req_rs_valid_i  in  NumRs  operand valid mask
issue_valid_o  out  1  X-IF issue valid
issue_ready_i  in  1  X-IF issue ready
issue_instr_o  out  32  registered instruction
issue_rs_o  out  NumRs*XLEN  registered operands
issue_rs_valid_o  out  NumRs  registered operand mask
issue_id_o  out  IdWidth  transaction ID
issue_accept_i  in  1  coprocessor accepts instruction
issue_writeback_i  in  1  coprocessor will return a result
commit_valid_o  out  1  X-IF commit valid (single-cycle pulse)
commit_id_o  out  IdWidth  committed ID
commit_kill_o  out  1  kill committed transaction
result_valid_i  in  1  X-IF result valid
result_ready_o  out  1  X-IF result ready
result_id_i  in  IdWidth  result ID
result_rd_i  in  5  destination register
result_data_i  in  XLEN  result data
result_we_i  in  1  result write enable
wb_we_o  out  1  register-file write enable
wb_addr_o  out  5  register-file write address
wb_data_o  out  XLEN  register-file write data
outstanding_o  out  $clog2(MaxOutstanding+1)  count of in-flight transactions
busy_o  out  1  stage cannot take a request
reject_o  out  1  pulse: coprocessor rejected instruction
err_id_o  out  1  pulse: result with ID not outstanding

Behaviour:
- Reset: state IDLE. All outputs 0. Scoreboard clear. Next-ID counter 0. outstanding_o 0.
- FSM states:
  - IDLE: req_ready_o = 1 iff outstanding < MaxOutstanding. On req_valid_i & req_ready_o: latch instr/rs/rs_valid, assign issue_id_o = next-ID, go to ISSUE.
  - ISSUE: issue_valid_o = 1; payload held stable until issue_ready_i. On the handshake cycle, next-ID increments (wraps mod 2**IdWidth) and the state goes to COMMIT.
    - If issue_accept_i & issue_writeback_i: set scoreboard[id].
    - If !issue_accept_i: record reject.
  - COMMIT: commit_valid_o = 1 for exactly one cycle, commit_id_o = issued ID, commit_kill_o = rejected flag. reject_o pulses in the same cycle if rejected. Return to IDLE.
- busy_o = (state != IDLE) | (outstanding == MaxOutstanding).
- Request-to-issue latency: 1 cycle. Minimum back-to-back request spacing: 3 cycles.
- Result path:
  - result_ready_o = 1 at all times outside reset.
  - On result_valid_i: if scoreboard[result_id_i] is set, clear it and register writeback. Next cycle wb_we_o = result_we_i & (result_rd_i != 0), with wb_addr_o/wb_data_o valid; wb_we_o is a one-cycle pulse.
  - If the ID is not outstanding: no writeback, err_id_o pulses next cycle.
- outstanding_o = popcount(scoreboard). An allocation and a retirement in the same cycle leave it unchanged. A same-ID allocate-and-retire cannot occur: IDs are not reissued while set. If the next-ID is still set in the scoreboard, req_ready_o = 0.
- Accepted instructions without writeback are not counted.
- Asynchronous reset mid-transaction: immediate return to IDLE, scoreboard cleared. In-flight results are dropped.

Optional Feature:
ISOLDE_XIF_SEQ_TIMEOUT_EN
- Defined: a per-scoreboard-entry counter starts at allocation.
  - If TimeoutCycles elapse without a result, the entry is cleared and err_id_o pulses with the stale ID.
  - A late result for that ID then also flags err_id_o.
- Undefined: no counters are built; entries wait indefinitely.

Test Plan:
- Single op: req instr=0x0000_702B, rs={1,2,3}, issue_ready=1, accept=1, writeback=1 -> issue_valid for 1 cycle, ID 0, commit_valid with kill=0 two cycles after req. Result id=0, rd=5, data=0xDEADBEEF -> wb_we=1, addr=5, data=0xDEADBEEF next cycle; outstanding back to 0.
- Issue back-pressure: issue_ready held 0 for 5 cycles -> issue_valid and payload stable for 6 cycles, req_ready=0, busy=1 throughout.
- Reject: accept=0 -> commit_kill=1, reject_o=1 for 1 cycle, outstanding stays 0, no writeback.
- Saturation: 4 accepted writeback ops, no results -> busy=1, req_ready=0, outstanding=4. A result for id 2 frees a slot; the next op takes id 4.
- Edge results: result with rd=0 -> wb_we=0. Result with an ID never issued -> err_id_o pulse, scoreboard unchanged. Result and allocation in the same cycle -> outstanding unchanged.
- Reset mid-ISSUE: g_rst_n low -> all outputs 0 immediately; after release the next op uses ID 0.
